// File: rtl/adv7513_int_pkg.sv
// Shared types and defaults for the ADV7513 interrupt conditioner.
//   state_e        : conditioner FSM states
//   DEF_*          : default filter / holdoff / stuck-detect parameters
//   EVENT_W/GLITCH_W : statistics counter widths
package adv7513_int_pkg;

  localparam int unsigned DEF_FILTER_CYCLES  = 16;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 64;
  localparam int unsigned DEF_STUCK_CYCLES   = 1048576;
  localparam int unsigned DEF_CNT_W          = 21;

  localparam int unsigned EVENT_W  = 16;
  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL_LO = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_QUAL_HI = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

endpackage

// File: rtl/adv7513_int_conditioner_if.sv
// Pin/status bundle between the INT conditioner and its environment.
//   int_n_pin, enable, stat_clear : into the conditioner
//   int_n_out, event_count, glitch_count, stuck_low : out of the conditioner
//   master : environment side (pin source, driver/PIO)
//   slave  : conditioner side
interface adv7513_int_conditioner_if;
  import adv7513_int_pkg::*;

  logic                int_n_pin;
  logic                enable;
  logic                stat_clear;
  logic                int_n_out;
  logic [EVENT_W-1:0]  event_count;
  logic [GLITCH_W-1:0] glitch_count;
  logic                stuck_low;

  modport master (
    output int_n_pin, enable, stat_clear,
    input  int_n_out, event_count, glitch_count, stuck_low
  );

  modport slave (
    input  int_n_pin, enable, stat_clear,
    output int_n_out, event_count, glitch_count, stuck_low
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
//   clk, reset : sampling clock, async active-high reset
//   d          : asynchronous input
//   q          : d delayed by two clk edges, reset to RESET_VAL
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adv7513_int_conditioner.sv
// Conditions the ADV7513 open-drain active-low INT pin: synchronise, reject
// short low pulses, hold off after each release, and track statistics.
//   clk, reset : system clock, async active-high reset
//   bus.int_n_pin   : raw INT pin (async, active-low)
//   bus.enable      : 0 parks the FSM in IDLE with int_n_out high
//   bus.stat_clear  : pulse clears event_count, glitch_count, stuck_low
//   bus.int_n_out   : conditioned active-low interrupt
//   bus.event_count : accepted assertions (saturating)
//   bus.glitch_count: rejected low pulses (saturating)
//   bus.stuck_low   : sticky flag, asserted dwell >= STUCK_CYCLES
module adv7513_int_conditioner
  import adv7513_int_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned STUCK_CYCLES   = DEF_STUCK_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      reset,
  adv7513_int_conditioner_if.slave bus
);

  logic                sync_n;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d, timer_inc;
  logic [CNT_W-1:0]    stuck_tmr_q, stuck_tmr_d;
  logic                int_n_q, int_n_d;
  logic [EVENT_W-1:0]  event_q, event_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                stuck_q, stuck_d;
  logic                ev_inc, gl_inc, st_set;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.int_n_pin),
    .q     (sync_n)
  );

  assign timer_inc = timer_q + CNT_W'(1);

  // Next-state, timers and statistics
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stuck_tmr_d = '0;
    int_n_d     = int_n_q;
    ev_inc      = 1'b0;
    gl_inc      = 1'b0;
    st_set      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!sync_n) begin
          state_d = ST_QUAL_LO;
          timer_d = CNT_W'(1);
        end
      end
      ST_QUAL_LO: begin
        if (sync_n) begin
          state_d = ST_IDLE;
          timer_d = '0;
          gl_inc  = 1'b1;
        end else if (timer_inc == CNT_W'(FILTER_CYCLES)) begin
          state_d = ST_ACTIVE;
          timer_d = '0;
          int_n_d = 1'b0;
          ev_inc  = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_ACTIVE: begin
        if (sync_n) begin
          state_d = ST_QUAL_HI;
          timer_d = CNT_W'(1);
        end
      end
      ST_QUAL_HI: begin
        if (!sync_n) begin
          state_d = ST_ACTIVE;
          timer_d = '0;
        end else if (timer_inc == CNT_W'(FILTER_CYCLES)) begin
          state_d = ST_HOLDOFF;
          timer_d = '0;
          int_n_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_HOLDOFF: begin
        if (timer_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        int_n_d = 1'b1;
      end
    endcase

    // Stuck timer runs across ACTIVE/QUAL_HI bounces; zero everywhere else,
    // which also clears it on the way into HOLDOFF.
    if ((state_q == ST_ACTIVE || state_q == ST_QUAL_HI) && state_d != ST_HOLDOFF) begin
      stuck_tmr_d = (stuck_tmr_q == '1) ? stuck_tmr_q : stuck_tmr_q + CNT_W'(1);
    end
    if ((state_q == ST_ACTIVE || state_q == ST_QUAL_HI) &&
        stuck_tmr_q >= CNT_W'(STUCK_CYCLES - 1)) begin
      st_set = 1'b1;
    end

    // Disable parks everything without holdoff and without touching counters
    if (!bus.enable) begin
      state_d     = ST_IDLE;
      timer_d     = '0;
      stuck_tmr_d = '0;
      int_n_d     = 1'b1;
      ev_inc      = 1'b0;
      gl_inc      = 1'b0;
      st_set      = 1'b0;
    end

    event_d  = (ev_inc && event_q != '1)  ? event_q + EVENT_W'(1)   : event_q;
    glitch_d = (gl_inc && glitch_q != '1) ? glitch_q + GLITCH_W'(1) : glitch_q;
    stuck_d  = stuck_q | st_set;

    // Clear beats a simultaneous increment
    if (bus.stat_clear) begin
      event_d  = '0;
      glitch_d = '0;
      stuck_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      stuck_tmr_q <= '0;
      int_n_q     <= 1'b1;
      event_q     <= '0;
      glitch_q    <= '0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stuck_tmr_q <= stuck_tmr_d;
      int_n_q     <= int_n_d;
      event_q     <= event_d;
      glitch_q    <= glitch_d;
      stuck_q     <= stuck_d;
    end
  end

  assign bus.int_n_out    = int_n_q;
  assign bus.event_count  = event_q;
  assign bus.glitch_count = glitch_q;
  assign bus.stuck_low    = stuck_q;

endmodule
